// File: rtl/operand_display_pkg.sv
// Shared FSM state encoding, display symbol codes and the active-low
// seven-segment patterns used by operand_display and seg7_decoder.
package operand_display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_CAPTURE,
    ST_CONV_H,
    ST_CONV_T,
    ST_DONE
  } state_t;

  localparam logic [3:0] CODE_MINUS = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Cathode pattern (gfedcba, active-low); unused codes 11..14 go blank.
  function automatic logic [6:0] seg_pattern(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      4'd10:   s = SEG_MINUS;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/operand_display_seg7.sv
// Combinational 4-bit symbol code to active-low seven-segment cathode decoder.
module seg7_decoder
  import operand_display_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  assign o_seg = seg_pattern(i_code);

endmodule

// File: rtl/operand_display.sv
// Reads a signed 16-bit operand from BRAM, converts it to sign + three BCD
// digits by repeated subtraction, and scans it onto a 4-digit 7-seg display.
//
// state   | meaning
// IDLE    | display stable, waiting for a trigger
// READ    | bram_en high for one cycle, bram_addr = sel
// WAIT    | hold RD_LATENCY cycles for BRAM data
// CAPTURE | range check; overrange skips conversion
// CONV_H  | subtract 100 per cycle into hundreds
// CONV_T  | subtract 10 per cycle into tens, remainder is ones
// DONE    | digits committed, valid raised; re-read if pending
module operand_display
  import operand_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        reload,
  output logic        bram_en,
  output logic        bram_addr,
  input  logic [15:0] bram_dout,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        valid,
  output logic        overrange
);

  localparam int              CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [1:0]      WAIT_LOAD = 2'(RD_LATENCY - 1);

  state_t             r_state;
  logic               r_pending;
  logic               r_boot;
  logic               r_sel_q;
  logic               r_bram_en;
  logic               r_bram_addr;
  logic               r_valid;
  logic               r_overrange;
  logic               r_neg;
  logic [9:0]         r_mag;
  logic [3:0]         r_hund;
  logic [3:0]         r_tens;
  logic [1:0]         r_wait;
  logic [3:0]         r_dig [4];
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_slot;
  logic               r_scan_on;

  logic               w_trig;
  logic signed [15:0] w_value;
  logic               w_over;
  logic [9:0]         w_mag;
  logic [3:0]         w_code;

  assign w_trig  = r_boot | (sel != r_sel_q) | reload;
  assign w_value = bram_dout;
  assign w_over  = (w_value > 16'sd999) || (w_value < -16'sd999);
  // In range |value| <= 999 fits in 10 bits, so the low bits negate exactly.
  assign w_mag   = bram_dout[15] ? (10'd0 - bram_dout[9:0]) : bram_dout[9:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pending   <= 1'b0;
      r_boot      <= 1'b1;
      r_sel_q     <= 1'b0;
      r_bram_en   <= 1'b0;
      r_bram_addr <= 1'b0;
      r_valid     <= 1'b0;
      r_overrange <= 1'b0;
      r_neg       <= 1'b0;
      r_mag       <= '0;
      r_hund      <= '0;
      r_tens      <= '0;
      r_wait      <= '0;
      for (int i = 0; i < 4; i++) r_dig[i] <= CODE_BLANK;
    end else begin
      r_sel_q <= sel;
      r_boot  <= 1'b0;
      if (r_state != ST_IDLE && w_trig) r_pending <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_trig) begin
            r_state     <= ST_READ;
            r_bram_en   <= 1'b1;
            r_bram_addr <= sel;
            r_valid     <= 1'b0;
            r_pending   <= 1'b0;
          end
        end
        ST_READ: begin
          r_bram_en <= 1'b0;
          r_wait    <= WAIT_LOAD;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_wait == 2'd0) r_state <= ST_CAPTURE;
          else                r_wait  <= r_wait - 2'd1;
        end
        ST_CAPTURE: begin
          r_overrange <= w_over;
          if (w_over) begin
            for (int i = 0; i < 4; i++) r_dig[i] <= CODE_MINUS;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_neg   <= bram_dout[15];
            r_mag   <= w_mag;
            r_hund  <= '0;
            r_tens  <= '0;
            r_state <= ST_CONV_H;
          end
        end
        ST_CONV_H: begin
          if (r_mag >= 10'd100) begin
            r_mag  <= r_mag - 10'd100;
            r_hund <= r_hund + 4'd1;
          end else begin
            r_state <= ST_CONV_T;
          end
        end
        ST_CONV_T: begin
          if (r_mag >= 10'd10) begin
            r_mag  <= r_mag - 10'd10;
            r_tens <= r_tens + 4'd1;
          end else begin
            r_dig[3] <= r_neg ? CODE_MINUS : CODE_BLANK;
            r_dig[2] <= r_hund;
            r_dig[1] <= r_tens;
            r_dig[0] <= r_mag[3:0];
            r_valid  <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (r_pending || w_trig) begin
            r_state     <= ST_READ;
            r_bram_en   <= 1'b1;
            r_bram_addr <= sel;
            r_valid     <= 1'b0;
            r_pending   <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_slot    <= '0;
      r_scan_on <= 1'b0;
    end else begin
      r_scan_on <= 1'b1;
      if (r_cnt == CNT_LAST) begin
        r_cnt  <= '0;
        r_slot <= r_slot + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_code = r_dig[r_slot];

  seg7_decoder u_seg7 (
    .i_code (w_code),
    .o_seg  (seg)
  );

  assign an        = r_scan_on ? ~(4'b0001 << r_slot) : 4'b1111;
  assign bram_en   = r_bram_en;
  assign bram_addr = r_bram_addr;
  assign valid     = r_valid;
  assign overrange = r_overrange;

endmodule

// File: tb/tb_operand_display.sv
// Bench for operand_display: BRAM model, display scoreboard from decimal
// arithmetic, directed literal scenarios and a randomized trigger phase.
module tb_operand_display;

  localparam int DIV = 4;
  localparam int LAT = 1;
  localparam logic [3:0] C_MINUS = 4'd10;
  localparam logic [3:0] C_BLANK = 4'd15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        reload = 1'b0;
  logic        bram_en;
  logic        bram_addr;
  logic [15:0] bram_dout = 16'h0000;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        valid;
  logic        overrange;

  operand_display #(.REFRESH_DIV(DIV), .RD_LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .reload    (reload),
    .bram_en   (bram_en),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout),
    .seg       (seg),
    .an        (an),
    .valid     (valid),
    .overrange (overrange)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [2];
  logic [15:0] rdq [$];
  logic [15:0] popped [$];
  logic [3:0]  exp_dig [4];
  logic        exp_ovr;
  int          n_tests = 0;
  int          n_fail = 0;
  int          valid_rises = 0;
  int          en_count = 0;

  function automatic logic [6:0] pat(input logic [3:0] c);
    case (c)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  4'd10: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [3:0] sym(input logic [6:0] s);
    for (int c = 0; c <= 10; c++) if (pat(4'(c)) == s) return 4'(c);
    if (s == 7'h7F) return C_BLANK;
    return 4'd14;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // What the display must show for a captured BRAM word, in decimal terms.
  task automatic model(input logic [15:0] v);
    int sv, mag;
    sv = int'($signed(v));
    if (sv > 999 || sv < -999) begin
      for (int i = 0; i < 4; i++) exp_dig[i] = C_MINUS;
      exp_ovr = 1'b1;
    end else begin
      mag = (sv < 0) ? -sv : sv;
      exp_dig[3] = (sv < 0) ? C_MINUS : C_BLANK;
      exp_dig[2] = 4'(mag / 100);
      exp_dig[1] = 4'((mag / 10) % 10);
      exp_dig[0] = 4'(mag % 10);
      exp_ovr = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (bram_en) begin
      bram_dout <= mem[bram_addr];
      rdq.push_back(mem[bram_addr]);
    end
  end

  initial begin
    logic       prev_valid = 1'b0;
    logic [3:0] prev_an = 4'hF;
    logic       first_run = 1'b1;
    int         run = 0;
    int         pos;
    logic [15:0] v;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_valid", valid, 0);
        check("rst_ovr", overrange, 0);
        check("rst_en", bram_en, 0);
        check("rst_addr", bram_addr, 0);
        for (int i = 0; i < 4; i++) exp_dig[i] = C_BLANK;
        exp_ovr = 1'b0;
        rdq.delete();
        prev_valid = 1'b0;
        prev_an = 4'hF;
        first_run = 1'b1;
        run = 0;
      end else begin
        if (valid && !prev_valid) begin
          check("reads_per_done", rdq.size(), 1);
          if (rdq.size() > 0) begin
            v = rdq.pop_front();
            popped.push_back(v);
            model(v);
          end
          valid_rises++;
        end
        prev_valid = valid;
        if (bram_en) begin
          check("valid_low_in_read", valid, 0);
          en_count++;
        end
        if (valid) check("overrange", overrange, exp_ovr);
        check("one_anode", $countones(~an), 1);
        pos = 0;
        for (int i = 0; i < 4; i++) if (an[i] == 1'b0) pos = i;
        check("seg", seg, pat(exp_dig[pos]));
        if (an != prev_an) begin
          if (prev_an != 4'hF) begin
            check("an_rotate", an, {prev_an[2:0], prev_an[3]});
            if (!first_run) check("an_hold", run, DIV);
            first_run = 1'b0;
          end
          prev_an = an;
          run = 1;
        end else begin
          run++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reload();
    @(negedge clk) reload = 1'b1;
    @(negedge clk) reload = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max_cyc);
    int n = 0;
    while (n < max_cyc && valid !== 1'b1) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(name, valid, 1);
  endtask

  task automatic check_disp(input string name, input logic [15:0] exp);
    logic [15:0] d = 16'hEEEE;
    for (int k = 0; k < 4 * DIV + 2; k++) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) if (an[i] == 1'b0) d[i*4 +: 4] = sym(seg);
    end
    check(name, d, exp);
  endtask

  function automatic logic [15:0] rand_val();
    logic [15:0] b [8];
    int t;
    b = '{16'd999, 16'hFC19, 16'd1000, 16'hFC18, 16'd0, 16'h8000, 16'h7FFF, 16'hFFFF};
    case ($urandom_range(0, 3))
      0: begin t = int'($urandom_range(0, 1998)) - 999; return 16'(t); end
      1: return 16'($urandom);
      2: return b[$urandom_range(0, 7)];
      default: begin t = int'($urandom_range(0, 40)) - 20; return 16'(t); end
    endcase
  endfunction

  logic [15:0] tv [6];
  logic [15:0] te [6];
  logic        to [6];

  initial begin
    int cnt;
    tv = '{16'd1000, 16'h8000, 16'd0, 16'hFC19, 16'hFC18, 16'd10};
    te = '{16'hAAAA, 16'hAAAA, 16'hF000, 16'hA999, 16'hAAAA, 16'hF010};
    to = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    mem[0] = 16'd123;
    mem[1] = 16'hFFD3;
    tick(3);
    reset = 1'b0;
    wait_valid("boot_valid", 24);
    check_disp("boot_disp", 16'hF123);

    @(negedge clk) sel = 1'b1;
    @(posedge clk);
    #2;
    check("sel_valid_drop", valid, 0);
    wait_valid("sel_valid", 24);
    check_disp("sel_disp", 16'hA045);
    check("sel_ovr", overrange, 0);

    @(negedge clk) sel = 1'b0;
    tick(2);
    wait_valid("sel0_valid", 24);
    for (int i = 0; i < 6; i++) begin
      mem[0] = tv[i];
      pulse_reload();
      wait_valid("table_valid", 24);
      check("table_ovr", overrange, to[i]);
      check_disp("table_disp", te[i]);
    end

    // Worst-case conversion: count edges from the one that samples reload.
    mem[0] = 16'd999;
    @(negedge clk) reload = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk);
      #2;
      cnt++;
      reload = 1'b0;
    end while (valid !== 1'b1 && cnt < 40);
    check("worst_latency_ok", (cnt <= 24), 1);
    check_disp("worst_disp", 16'hF999);

    // Reload during CONV_H with a data change: one collapsed re-read.
    popped.delete();
    valid_rises = 0;
    en_count = 0;
    pulse_reload();
    tick(4);
    mem[0] = 16'd7;
    reload = 1'b1;
    @(negedge clk) reload = 1'b0;
    tick(60);
    check("rr_dones", valid_rises, 2);
    check("rr_reads", en_count, 2);
    check("rr_first", (popped.size() > 0) ? popped[0] : 16'hDEAD, 16'd999);
    check("rr_second", (popped.size() > 1) ? popped[1] : 16'hDEAD, 16'd7);
    check_disp("rr_disp", 16'hF007);

    // Reset landing in CONV_T.
    mem[0] = 16'd999;
    pulse_reload();
    tick(15);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    wait_valid("abort_valid", 30);
    check_disp("abort_disp", 16'hF999);

    repeat (150) begin
      @(negedge clk);
      case ($urandom_range(0, 9))
        0, 1, 2: mem[$urandom_range(0, 1)] = rand_val();
        3, 4:    sel = ~sel;
        5, 6:    begin reload = 1'b1; @(negedge clk) reload = 1'b0; end
        7:       begin mem[sel] = rand_val(); reload = 1'b1; @(negedge clk) reload = 1'b0; end
        8:       if ($urandom_range(0, 3) == 0) begin reset = 1'b1; @(negedge clk) reset = 1'b0; end
        default: ;
      endcase
      tick($urandom_range(0, 30));
    end
    tick(60);
    check("final_valid", valid, 1);
    check("final_matches_sel", (popped.size() > 0) ? popped[popped.size()-1] : 16'hDEAD, mem[sel]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
